// File: rtl/bus_dma_master_pkg.sv
// Shared constants for the bus DMA master: widths, FSM state encoding and bus command values.
package bus_dma_master_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned STATE_W    = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] S_RD   = 3'd2;
    localparam logic [STATE_W-1:0] S_CAP  = 3'd3;
    localparam logic [STATE_W-1:0] S_WR   = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE = 3'd5;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/bus_dma_master_if.sv
// Shared-bus master port: request/grant handshake, command, address and data.
interface bus_dma_master_if
    import bus_dma_master_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              M_req;
    logic              M_grant;
    logic              M_wr;
    logic [ADDR_W-1:0] M_addr;
    logic [DATA_W-1:0] M_dout;
    logic [DATA_W-1:0] M_din;

    modport master (
        output M_req, M_wr, M_addr, M_dout,
        input  M_grant, M_din
    );

    modport slave (
        input  M_req, M_wr, M_addr, M_dout,
        output M_grant, M_din
    );

endinterface

// File: rtl/dma_addr_gen.sv
// Captured copy parameters, word index and wrapping source/destination address generation.
module dma_addr_gen
    import bus_dma_master_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] src_addr_c,
    output logic [ADDR_W-1:0] dst_addr_c,
    output logic              last_c
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  idx_d;

    assign idx_d = inc ? LEN_W'(idx_q + LEN_W'(1)) : idx_q;

    // Addresses reflect the index the word will use after this edge, so the
    // top can register them into M_addr on the same edge the FSM advances.
    assign src_addr_c = ADDR_W'(src_q + ADDR_W'(idx_d));
    assign dst_addr_c = ADDR_W'(dst_q + ADDR_W'(idx_d));
    assign last_c     = (LEN_W'(idx_q + LEN_W'(1)) == len_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            src_q <= src_in;
            dst_q <= dst_in;
            len_q <= len_in;
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/bus_dma_master.sv
// Bus DMA master: copies LENGTH words from a source range to a destination range over the shared bus.
module bus_dma_master
    import bus_dma_master_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    bus_dma_master_if.master  bus,
    output logic              busy,
    output logic              done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               req_q, req_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  buf_q, buf_d;
    logic               busy_d, done_d;

    logic               load;
    logic               inc;
    logic               last_c;
    logic [ADDR_W-1:0]  src_cur_c;
    logic [ADDR_W-1:0]  dst_cur_c;

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .inc        (inc),
        .src_in     (src_addr),
        .dst_in     (dst_addr),
        .len_in     (length),
        .src_addr_c (src_cur_c),
        .dst_addr_c (dst_cur_c),
        .last_c     (last_c)
    );

    // Index control strobes, kept apart from the FSM block that consumes the addresses
    assign load = (state_q == S_IDLE) && start && (length != '0);
    assign inc  = (state_q == S_WR) && bus.M_grant && !last_c;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        buf_d   = buf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length != '0) ? S_REQ : S_DONE;
                end
            end
            // Grant is the registered request, so it is up by the RD cycle;
            // RD confirms it and falls back to REQ while it is missing.
            S_REQ:   state_d = S_RD;
            S_RD:    state_d = bus.M_grant ? S_CAP : S_REQ;
            S_CAP:   state_d = bus.M_grant ? S_WR : S_REQ;
            S_WR: begin
                if (!bus.M_grant) begin
                    state_d = S_REQ;
                end else if (last_c) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_d  = (state_d inside {S_REQ, S_RD, S_CAP, S_WR});
        wr_d   = (state_d == S_WR) ? CMD_WR : CMD_RD;
        busy_d = req_d;
        done_d = (state_d == S_DONE);

        if (state_d == S_RD) begin
            addr_d = src_cur_c;
        end else if (state_d == S_WR) begin
            addr_d = dst_cur_c;
        end

        // Read data is valid during CAP; keep it only if the word proceeds to WR
        if ((state_q == S_CAP) && (state_d == S_WR)) begin
            buf_d = bus.M_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            wr_q    <= CMD_RD;
            addr_q  <= '0;
            buf_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign bus.M_req  = req_q;
    assign bus.M_wr   = wr_q;
    assign bus.M_addr = addr_q;
    assign bus.M_dout = buf_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master: table of copy jobs plus hand-written busy-start, reset and grant-drop cases.
module tb_bus_dma_master;
    import bus_dma_master_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [7:0]    length;
    logic          busy;
    logic          done;

    bus_dma_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_dma_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Bus model: registered grant, one-cycle read latency, flat 256-word memory for both slaves
    logic          grant_q;
    logic          drop_grant;
    logic [DW-1:0] din_q;
    logic [DW-1:0] mem [256];
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] wr_log [256];
    logic [AW-1:0] rd_log [256];
    int            wr_cnt = 0;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    assign bus.M_grant = grant_q & ~drop_grant;
    assign bus.M_din   = din_q;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) grant_q <= 1'b0;
        else          grant_q <= bus.M_req;
    end

    always @(posedge clk) begin
        prev_addr <= bus.M_addr;
        if (bus.M_req && !bus.M_wr) din_q <= mem[bus.M_addr];
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.M_req && bus.M_wr && bus.M_grant) begin
            mem[bus.M_addr]          <= bus.M_dout;
            wr_log[8'(wr_cnt)]       <= bus.M_addr;
            rd_log[8'(wr_cnt)]       <= prev_addr;
            wr_cnt                   <= wr_cnt + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_put(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  len;
        logic [31:0] seed;
        logic [31:0] step;
        int          lat;
        int          req_cyc;
    } vec_t;

    vec_t vt [6];

    initial begin
        int w0;
        int lat;
        int reqc;
        int dcnt;
        logic [7:0] a;

        vt[0] = '{8'h05, 8'h25, 8'd1, 32'hDEADBEEF, 32'h0,        5,  4};
        vt[1] = '{8'h00, 8'h20, 8'd3, 32'h11,       32'h11,       11, 10};
        vt[2] = '{8'h10, 8'h30, 8'd0, 32'h0,        32'h0,        1,  0};
        vt[3] = '{8'hFE, 8'h70, 8'd3, 32'hF00D0000, 32'h1,        11, 10};
        vt[4] = '{8'h40, 8'hFE, 8'd3, 32'h0BAD0000, 32'h100,      11, 10};
        vt[5] = '{8'h48, 8'h88, 8'd5, 32'h12345678, 32'h01010101, 17, 16};

        reset_n    = 1'b0;
        start      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        drop_grant = 1'b0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;
        tick();
        tick();
        check("rst M_req",  32'(bus.M_req),  32'd0);
        check("rst M_wr",   32'(bus.M_wr),   32'd0);
        check("rst M_addr", 32'(bus.M_addr), 32'd0);
        check("rst M_dout", bus.M_dout,      32'd0);
        check("rst busy",   32'(busy),       32'd0);
        check("rst done",   32'(done),       32'd0);
        reset_n = 1'b1;
        tick();

        // Table of copy jobs with cycle-level bus expectations
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < int'(vt[i].len); k++) begin
                a = 8'(vt[i].src + 8'(k));
                mem_put(a, vt[i].seed + 32'(k) * vt[i].step);
            end
            w0       = wr_cnt;
            src_addr = vt[i].src;
            dst_addr = vt[i].dst;
            length   = vt[i].len;
            start    = 1'b1;
            lat      = 0;
            reqc     = 0;
            for (int c = 1; c <= 40 && lat == 0; c++) begin
                int k;
                int ph;
                tick();
                if (c == 1) start = 1'b0;
                if (bus.M_req) reqc++;
                if (done) lat = c;
                if (c == 1 && vt[i].len != 0)
                    check($sformatf("v%0d busy", i), 32'({busy, bus.M_req, bus.M_wr}), 32'b110);
                if (c >= 2 && c <= 3 * int'(vt[i].len) + 1) begin
                    k  = (c - 2) / 3;
                    ph = (c - 2) % 3;
                    if (ph == 2)
                        check($sformatf("v%0d c%0d wr", i, c), 32'({bus.M_wr, bus.M_addr}),
                              32'({1'b1, 8'(vt[i].dst + 8'(k))}));
                    else
                        check($sformatf("v%0d c%0d rd", i, c), 32'({bus.M_wr, bus.M_addr}),
                              32'({1'b0, 8'(vt[i].src + 8'(k))}));
                end
                if (c == vt[i].lat)
                    check($sformatf("v%0d done st", i), 32'({bus.M_req, busy, bus.M_wr}), 32'd0);
            end
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("v%0d req cycles", i), 32'(reqc), 32'(vt[i].req_cyc));
            check($sformatf("v%0d writes", i), 32'(wr_cnt - w0), 32'(vt[i].len));
            for (int k = 0; k < int'(vt[i].len); k++) begin
                a = 8'(vt[i].dst + 8'(k));
                check($sformatf("v%0d rd addr %0d", i, k), 32'(rd_log[8'(w0 + k)]), 32'(8'(vt[i].src + 8'(k))));
                check($sformatf("v%0d wr addr %0d", i, k), 32'(wr_log[8'(w0 + k)]), 32'(a));
                check($sformatf("v%0d data %0d", i, k), mem[a], vt[i].seed + 32'(k) * vt[i].step);
            end
            tick();
            check($sformatf("v%0d done pulse", i), 32'(done), 32'd0);
        end

        // Start while busy: second start must be ignored
        for (int k = 0; k < 4; k++) mem_put(8'(8'h50 + 8'(k)), 32'hAA00 + 32'(k));
        mem_put(8'h98, 32'h5E5E5E5E);
        w0 = wr_cnt; src_addr = 8'h50; dst_addr = 8'h60; length = 8'd4; start = 1'b1;
        lat = 0; dcnt = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 3) begin start = 1'b1; src_addr = 8'h90; dst_addr = 8'h98; length = 8'd2; end
            if (c == 4) start = 1'b0;
            if (done) begin dcnt++; if (lat == 0) lat = c; end
        end
        check("busy-start latency", 32'(lat), 32'd14);
        check("busy-start done count", 32'(dcnt), 32'd1);
        check("busy-start writes", 32'(wr_cnt - w0), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("busy-start data %0d", k), mem[8'(8'h60 + 8'(k))], 32'hAA00 + 32'(k));
        check("busy-start untouched", mem[8'h98], 32'h5E5E5E5E);

        // Reset during the first WR cycle
        mem_put(8'hA0, 32'hA0A0A0A0);
        mem_put(8'hA1, 32'hA1A1A1A1);
        mem_put(8'hB0, 32'h5E5E5E5E);
        w0 = wr_cnt; src_addr = 8'hA0; dst_addr = 8'hB0; length = 8'd2; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        check("pre-reset in WR", 32'({bus.M_wr, bus.M_addr}), 32'({1'b1, 8'hB0}));
        #2;
        reset_n = 1'b0;
        #1;
        check("mid rst M_req",  32'(bus.M_req),  32'd0);
        check("mid rst M_wr",   32'(bus.M_wr),   32'd0);
        check("mid rst M_addr", 32'(bus.M_addr), 32'd0);
        check("mid rst M_dout", bus.M_dout,      32'd0);
        check("mid rst busy",   32'(busy),       32'd0);
        tick();
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done || bus.M_req) dcnt++;
        end
        check("mid rst no done/req", 32'(dcnt), 32'd0);
        check("mid rst writes", 32'(wr_cnt - w0), 32'd0);
        check("mid rst dst kept", mem[8'hB0], 32'h5E5E5E5E);

        // Grant dropped for one cycle during CAP of word 0: word retried
        for (int k = 0; k < 3; k++) mem_put(8'(8'hC0 + 8'(k)), 32'hC0DE0000 + 32'(k));
        w0 = wr_cnt; src_addr = 8'hC0; dst_addr = 8'hD0; length = 8'd3; start = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 3) begin
                check("drop in CAP", 32'({bus.M_req, bus.M_wr, bus.M_addr}), 32'({2'b10, 8'hC0}));
                drop_grant = 1'b1;
            end
            if (c == 4) begin
                drop_grant = 1'b0;
                check("drop back to REQ", 32'({bus.M_req, bus.M_wr, busy}), 32'b101);
            end
            if (done) lat = c;
        end
        check("drop latency", 32'(lat), 32'd14);
        check("drop writes", 32'(wr_cnt - w0), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drop wr addr %0d", k), 32'(wr_log[8'(w0 + k)]), 32'(8'(8'hD0 + 8'(k))));
            check($sformatf("drop data %0d", k), mem[8'(8'hD0 + 8'(k))], 32'hC0DE0000 + 32'(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
- Single-master bus initiator: the "M" side of the shared BUS (M_req/M_grant/M_wr/M_addr/M_dout/M_din).
- On a start pulse, copies LENGTH 32-bit words from a source address range to a destination address range.
- Every transfer goes through the bus. Sources and destinations may be slave 0, slave 1, or both.
- Sits between the top-level controller (testbench or CPU stub) and the BUS master port.

Parameters:
- ADDR_W, 8, bus address width (matches M_addr)
- DATA_W, 32, bus data width (matches M_dout/M_din)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; launch a copy (sampled in IDLE only)
- src_addr  input  ADDR_W  first source word address, captured on start
- dst_addr  input  ADDR_W  first destination word address, captured on start
- length  input  8  number of words to copy, captured on start; 0 legal
- M_grant  input  1  bus grant from arbiter (registered copy of M_req)
- M_din  input  DATA_W  read data from bus; valid the cycle after a read address is presented
- M_req  output  1  bus request
- M_wr  output  1  1 = write, 0 = read
- M_addr  output  ADDR_W  bus address
- M_dout  output  DATA_W  write data to bus
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse at completion

Behaviour:
- Reset (async, reset_n=0): state=IDLE. M_req=0, M_wr=0, M_addr=0, M_dout=0, busy=0, done=0. Index, buffer and captured addresses are cleared.
- All outputs are driven from the state register and datapath registers only. There is no combinational path from inputs to outputs.
- States: IDLE, REQ, RD, CAP, WR, DONE (shared encoding).
- IDLE, start=1, length!=0: capture src/dst/length, index=0, go to REQ, busy=1.
- IDLE, start=1, length=0: go to DONE directly. M_req is never raised.
- REQ: M_req=1, M_wr=0. Wait until M_grant=1, then go to RD. Nominal wait is 1 cycle because grant is the registered request.
- RD: M_req=1, M_wr=0, M_addr=src+index. Go to CAP.
- CAP: M_req=1, M_wr=0, M_addr held at src+index. Latch M_din into the buffer at the end of this cycle. Go to WR.
- WR: M_req=1, M_wr=1, M_addr=dst+index, M_dout=buffer.
  - If index+1==length: go to DONE.
  - Otherwise: index+=1 and go to RD.
- DONE: M_req=0, M_wr=0, done=1 for exactly one cycle, busy=0. Go to IDLE.
- Throughput: 3 cycles per word. Length N≥1 takes 3N+2 cycles from start to the done pulse (REQ 1, words 3N, DONE 1).
- M_req stays high continuously from REQ through the last WR. The bus is not released between words.
- Address arithmetic is modulo 2^ADDR_W: src+index and dst+index wrap (0xFF+1 = 0x00). Index counts 0..length-1 in 8 bits.
- Grant loss: if M_grant=0 in RD, CAP or WR, abandon the current word and return to REQ. Index is unchanged, so the word is retried. No write is issued for it.
- start while busy=1 is ignored. Captured parameters are stable for the whole copy.
- M_wr=1 only in WR. In all other states M_addr/M_dout hold their last value, except that reset zeroes them.
- Reset mid-copy: immediate return to reset values, no done pulse. Slave contents already written stay written.
- Overlapping src/dst ranges: copy proceeds in ascending order; no hazard handling.

Decomposition:
- Shared package: state encoding constants, ADDR_W/DATA_W defaults, bus command constants (RD=0, WR=1).
- One natural sub-module: dma_addr_gen. It holds the captured src/dst, the index counter, wrap-around adders and last-word compare. It outputs the current source/destination address and a `last` flag.
- The FSM and data buffer stay in the top module.

Test Plan:
- Single word: slave0[0x05]=0xDEADBEEF, start src=0x05 dst=0x25 len=1. Expect the done pulse 5 cycles after start and slave1[0x25]=0xDEADBEEF. The write cycle shows M_wr=1, M_addr=0x25.
- Multi-word: len=3, src=0x00 (words 0x11,0x22,0x33), dst=0x20. Expect slave1[0x20..0x22]=0x11,0x22,0x33, done after 11 cycles, and M_req high for 10 consecutive cycles.
- Zero length: start with len=0. Expect M_req never asserted and done high 1 cycle later.
- Wrap: src=0xFE len=3. Expect read addresses 0xFE, 0xFF, 0x00 in that order and destinations incrementing likewise.
- Start while busy: second start with different params mid-copy. Expect it ignored, the original copy to finish unchanged, and exactly one done pulse.
- Reset mid-copy and forced grant drop:
  - Assert reset_n=0 during a WR state. All outputs go to 0 immediately and no done pulse follows.
  - Force M_grant=0 for one cycle during CAP. The FSM re-enters REQ, retries the same index, and the final memory is correct.
